// File: rtl/cpu_sequencer.sv
// cpu_sequencer: FETCH/EXEC1/EXEC2 sequencer with memory stalls, branch delay slots,
// a zero-target-jump halt and saturating instruction/cycle counters.
package cpu_codes_pkg;
  typedef enum logic [1:0] {FETCH = 2'd0, EXEC1 = 2'd1, EXEC2 = 2'd2, HALT = 2'd3} state_t;
endpackage

module cpu_sequencer
  import cpu_codes_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest_i,
  input  logic        mem_access_i,
  input  logic        jump_i,
  input  logic        jump_target_zero_i,
  output state_t      state_o,
  output logic        active_o,
  output logic        stall_o,
  output logic        delay_slot_o,
  output logic [31:0] instr_count_o,
  output logic [31:0] cycle_count_o
);
  state_t      r_state;
  logic        r_delay_slot;
  logic        r_halt_pending;
  logic [31:0] r_instr_count;
  logic [31:0] r_cycle_count;
  logic        w_active;
  logic        w_wait;
  logic        w_complete;

  assign w_active   = r_state != HALT;
  assign w_wait     = mem_access_i && waitrequest_i;
  assign w_complete = w_active && !w_wait;

  assign state_o       = r_state;
  assign active_o      = w_active;
  assign stall_o       = w_active && w_wait;
  assign delay_slot_o  = r_delay_slot;
  assign instr_count_o = r_instr_count;
  assign cycle_count_o = r_cycle_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= FETCH;
      r_delay_slot   <= 1'b0;
      r_halt_pending <= 1'b0;
      r_instr_count  <= '0;
      r_cycle_count  <= '0;
    end else begin
      if (w_active)
        r_cycle_count <= r_cycle_count + {31'd0, ~&r_cycle_count};
      if (w_complete) begin
        case (r_state)
          FETCH: r_state <= EXEC1;
          EXEC1: r_state <= EXEC2;
          EXEC2: begin
            r_instr_count <= r_instr_count + {31'd0, ~&r_instr_count};
            // halt_pending is only ever set together with a delay slot, so the
            // halting instruction is always the one after the zero-target jump
            if (r_delay_slot && r_halt_pending) begin
              r_state        <= HALT;
              r_delay_slot   <= 1'b0;
              r_halt_pending <= 1'b0;
            end else begin
              r_state      <= FETCH;
              r_delay_slot <= jump_i;
              if (jump_i && jump_target_zero_i)
                r_halt_pending <= 1'b1;
            end
          end
          default: r_state <= HALT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed per-cycle vectors push expected outputs into a queue;
// a negedge monitor pops each entry and compares it against the DUT.
module tb_cpu_sequencer;
  import cpu_codes_pkg::*;

  typedef struct packed {
    logic [1:0]  st;
    logic        act;
    logic        stl;
    logic        dly;
    logic [31:0] ic;
    logic [31:0] cc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        waitrequest_i = 1'b0;
  logic        mem_access_i = 1'b0;
  logic        jump_i = 1'b0;
  logic        jump_target_zero_i = 1'b0;
  state_t      state_o;
  logic        active_o;
  logic        stall_o;
  logic        delay_slot_o;
  logic [31:0] instr_count_o;
  logic [31:0] cycle_count_o;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  cpu_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .waitrequest_i     (waitrequest_i),
    .mem_access_i      (mem_access_i),
    .jump_i            (jump_i),
    .jump_target_zero_i(jump_target_zero_i),
    .state_o           (state_o),
    .active_o          (active_o),
    .stall_o           (stall_o),
    .delay_slot_o      (delay_slot_o),
    .instr_count_o     (instr_count_o),
    .cycle_count_o     (cycle_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("state",      {30'd0, state_o}, {30'd0, e.st});
      chk("active",     {31'd0, active_o}, {31'd0, e.act});
      chk("stall",      {31'd0, stall_o}, {31'd0, e.stl});
      chk("delay_slot", {31'd0, delay_slot_o}, {31'd0, e.dly});
      chk("instr_count", instr_count_o, e.ic);
      chk("cycle_count", cycle_count_o, e.cc);
    end
  end

  // Inputs are driven just after a rising edge; the entry describes what the
  // DUT must show at the following falling edge.
  task automatic step(input logic rs, m, w, j, jz, input logic [1:0] es,
                      input logic est, ed, input logic [31:0] ei, ec);
    @(posedge clk);
    #1;
    reset = rs;
    mem_access_i = m;
    waitrequest_i = w;
    jump_i = j;
    jump_target_zero_i = jz;
    q.push_back(exp_t'{es, es != 2'd3, est, ed, ei, ec});
  endtask

  initial begin
    // reset state, then three plain instructions
    step(1, 0,0,0,0, 2'd0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++)
      step(0, 0,0,0,0, 2'(k % 3), 0, 0, 32'(k / 3), 32'(k));

    // FETCH stalled for four cycles
    step(1, 0,0,0,0, 2'd0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      step(0, 1,1,0,0, 2'd0, 1, 0, 0, 32'(k));
    step(0, 0,0,0,0, 2'd0, 0, 0, 0, 4);
    step(0, 0,0,0,0, 2'd1, 0, 0, 0, 5);

    // zero-target jump, delay slot with an EXEC1 stall, then halt
    step(1, 0,0,0,0, 2'd0, 0, 0, 0, 0);
    step(0, 0,0,0,0, 2'd0, 0, 0, 0, 0);
    step(0, 0,0,0,0, 2'd1, 0, 0, 0, 1);
    step(0, 0,0,1,1, 2'd2, 0, 0, 0, 2);
    step(0, 0,0,0,0, 2'd0, 0, 1, 1, 3);
    step(0, 1,1,0,0, 2'd1, 1, 1, 1, 4);
    step(0, 1,0,0,0, 2'd1, 0, 1, 1, 5);
    step(0, 0,0,0,0, 2'd2, 0, 1, 1, 6);
    step(0, 0,0,0,0, 2'd3, 0, 0, 2, 7);
    for (int k = 0; k < 10; k++)
      step(0, 1,1,1,1, 2'd3, 0, 0, 2, 7);

    // nonzero-target jump: delay slot for exactly three states, no halt
    step(1, 0,0,0,0, 2'd0, 0, 0, 0, 0);
    step(0, 0,0,0,0, 2'd0, 0, 0, 0, 0);
    step(0, 0,0,0,0, 2'd1, 0, 0, 0, 1);
    step(0, 0,0,1,0, 2'd2, 0, 0, 0, 2);
    step(0, 0,0,0,0, 2'd0, 0, 1, 1, 3);
    step(0, 0,0,0,0, 2'd1, 0, 1, 1, 4);
    step(0, 0,0,0,0, 2'd2, 0, 1, 1, 5);
    step(0, 0,0,0,0, 2'd0, 0, 0, 2, 6);
    step(0, 0,0,0,0, 2'd1, 0, 0, 2, 7);
    step(0, 0,0,0,0, 2'd2, 0, 0, 2, 8);
    step(0, 0,0,0,0, 2'd0, 0, 0, 3, 9);

    // zero-target jump inside a delay slot halts after the following instruction
    step(1, 0,0,0,0, 2'd0, 0, 0, 0, 0);
    step(0, 0,0,0,0, 2'd0, 0, 0, 0, 0);
    step(0, 0,0,0,0, 2'd1, 0, 0, 0, 1);
    step(0, 0,0,1,0, 2'd2, 0, 0, 0, 2);
    step(0, 0,0,0,0, 2'd0, 0, 1, 1, 3);
    step(0, 0,0,0,0, 2'd1, 0, 1, 1, 4);
    step(0, 0,0,1,1, 2'd2, 0, 1, 1, 5);
    step(0, 0,0,0,0, 2'd0, 0, 1, 2, 6);
    step(0, 0,0,0,0, 2'd1, 0, 1, 2, 7);
    step(0, 0,0,0,0, 2'd2, 0, 1, 2, 8);
    step(0, 0,0,0,0, 2'd3, 0, 0, 3, 9);
    step(0, 0,0,0,0, 2'd3, 0, 0, 3, 9);

    // async reset during an EXEC1 stall inside a pending-halt delay slot
    step(1, 0,0,0,0, 2'd0, 0, 0, 0, 0);
    step(0, 0,0,0,0, 2'd0, 0, 0, 0, 0);
    step(0, 0,0,0,0, 2'd1, 0, 0, 0, 1);
    step(0, 0,0,1,1, 2'd2, 0, 0, 0, 2);
    step(0, 0,0,0,0, 2'd0, 0, 1, 1, 3);
    step(0, 1,1,0,0, 2'd1, 1, 1, 1, 4);
    step(0, 1,1,0,0, 2'd1, 1, 1, 1, 5);
    step(1, 1,1,0,0, 2'd0, 1, 0, 0, 0);
    step(0, 0,0,0,0, 2'd0, 0, 0, 0, 0);
    step(0, 0,0,0,0, 2'd1, 0, 0, 0, 1);
    step(0, 0,0,0,0, 2'd2, 0, 0, 0, 2);
    step(0, 0,0,0,0, 2'd0, 0, 0, 1, 3);

    // saturation: preload counters just below the limit
    step(1, 0,0,0,0, 2'd0, 0, 0, 0, 0);
    step(0, 0,0,0,0, 2'd0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    force dut.r_cycle_count = 32'hFFFF_FFFE;
    force dut.r_instr_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_cycle_count;
    release dut.r_instr_count;
    step(0, 0,0,0,0, 2'd1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(0, 0,0,0,0, 2'd2, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(0, 0,0,0,0, 2'd0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(0, 0,0,0,0, 2'd1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    for (int k = 0; k < 20 && q.size() != 0; k++)
      @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
